// File: rtl/uart_pkg.sv
// Shared UART definitions: frame defaults, FSM state encodings and the width helper.
// Used by the receive sequencer, the transmitter and the baud-rate configuration.
package uart_pkg;

    localparam int DBIT_DEF    = 8;
    localparam int SB_TICK_DEF = 16;
    localparam int OVS_DEF     = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    // Bits needed to count 0..value-1, never less than one.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous pad input, with a chosen reset value.
// Latency: 2 clk. No backpressure: samples every clk.
// Reset: synchronous, active-high; both flops load RST_VAL.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: oversampled start/data/stop FSM presenting one byte per frame.
// Latency: 2 clk sync + OVS/2 + DBIT*OVS + SB_TICK ticks to rx_done_tick; no backpressure, dout held.
// Optional UART_RX_PARITY_EN adds a parity bit phase and the parity_err output.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int DBIT    = DBIT_DEF,
    parameter int SB_TICK = SB_TICK_DEF,
    parameter int OVS     = OVS_DEF
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    input  logic            s_tick,
    output logic [DBIT-1:0] dout,
    output logic            rx_done_tick,
    output logic            frame_err,
`ifdef UART_RX_PARITY_EN
    output logic            parity_err,
`endif
    output logic            busy
);

    localparam int SW = clog2((OVS > SB_TICK) ? OVS : SB_TICK);
    localparam int NW = clog2(DBIT);

    localparam logic [SW-1:0] S_MID  = SW'(OVS / 2 - 1);
    localparam logic [SW-1:0] S_BIT  = SW'(OVS - 1);
    localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

    logic            rx_s;
    uart_state_t     state_q, state_d;
    logic [SW-1:0]   s_q, s_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DBIT-1:0] shift_q, shift_d;
    logic [DBIT-1:0] dout_q, dout_d;
    logic            frame_err_q, frame_err_d;
    logic            done_q, done_d;
`ifdef UART_RX_PARITY_EN
    logic            par_pend_q, par_pend_d;
    logic            parity_err_q, parity_err_d;
`endif

    sync_2ff #(.RST_VAL(1'b1)) u_rx_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        n_d         = n_q;
        shift_d     = shift_q;
        dout_d      = dout_q;
        frame_err_d = frame_err_q;
        done_d      = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_pend_d   = par_pend_q;
        parity_err_d = parity_err_q;
`endif
        unique case (state_q)
            // Edge detect runs every clk so the start bit phase is not quantised to a tick.
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    s_d     = '0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_q == S_MID) begin
                        if (!rx_s) begin
                            state_d = DATA;
                            s_d     = '0;
                            n_d     = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_q == S_BIT) begin
                        s_d     = '0;
                        shift_d = {rx_s, shift_q[DBIT-1:1]};
                        if (n_q == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end else begin
                            n_d = n_q + 1'b1;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (s_tick) begin
                    if (s_q == S_BIT) begin
                        s_d        = '0;
                        par_pend_d = ^shift_q ^ rx_s ^ PARITY_ODD;
                        state_d    = STOP;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
`endif
            STOP: begin
                if (s_tick) begin
                    if (s_q == S_STOP) begin
                        s_d         = '0;
                        dout_d      = shift_q;
                        frame_err_d = ~rx_s;
                        done_d      = 1'b1;
`ifdef UART_RX_PARITY_EN
                        parity_err_d = par_pend_q;
`endif
                        state_d     = IDLE;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            s_q         <= '0;
            n_q         <= '0;
            shift_q     <= '0;
            dout_q      <= '0;
            frame_err_q <= 1'b0;
            done_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_pend_q   <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            n_q         <= n_d;
            shift_q     <= shift_d;
            dout_q      <= dout_d;
            frame_err_q <= frame_err_d;
            done_q      <= done_d;
`ifdef UART_RX_PARITY_EN
            par_pend_q   <= par_pend_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign dout         = dout_q;
    assign rx_done_tick = done_q;
    assign frame_err    = frame_err_q;
    assign busy         = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_err   = parity_err_q;
`endif

endmodule
